tiny_rv_hazard_ctrl: RTL and testbench
======================================

# tiny_rv_hazard_ctrl

Pipeline hazard and flush controller for the tiny_rv core. It generates the stall and flush strobes for the front end (fetch/decode), the register-read (RR) latch and the back end (EX/MEM). Each cycle it decides between three actions: hold everything while data memory is busy, squash on a control-flow redirect, or insert RR bubbles on a load-use hazard that operand forwarding cannot cover. It also keeps two free-running performance counters.

## Interface
- LOAD_LAT, 2: cycles after a load leaves RR until its result appears on the forwarding nets; legal range 1..4.
- i_clk  in  1  clock
- i_reset  in  1  reset, synchronous, active-high
- i_dec_opcode  in  7  opcode of the instruction in decode
- i_dec_rs1, i_dec_rs2  in  5 each  source registers of the instruction in decode
- i_rr_opcode  in  7  opcode held in the RR latch
- i_rr_rd  in  5  destination register held in the RR latch
- i_mem_busy  in  1  data memory not ready; back end must hold
- i_ex_redirect  in  1  taken branch or jump resolved in EX this cycle
- o_stall_front  out  1  hold fetch and decode
- o_flush_front  out  1  zero fetch and decode
- o_stall_rr  out  1  drives the RR latch i_pipe_stall
- o_flush_rr  out  1  drives the RR latch i_pipe_flush (bubble)
- o_stall_back  out  1  hold EX and MEM
- o_hazard_cnt  out  32  count of load-use bubble cycles
- o_memwait_cnt  out  32  count of memory-wait cycles

## Operation
- LOAD means opcode 7'b0000011.
- rs1 is compared for every opcode except LUI (0110111), AUIPC (0010111) and JAL (1101111).
- rs2 is compared only for R (0110011), S (0100011) and B (1100011) opcodes.
- A compared register equal to 0 never matches.
- Scoreboard: a shift register of LOAD_LAT-1 entries, each {valid, rd}. With LOAD_LAT=1 the scoreboard is empty.
  - Entry 0 loads {1, i_rr_rd} when the back end advances, RR is not flushed, i_rr_opcode is LOAD and i_rr_rd≠0. Otherwise entry 0 loads {0, x}.
  - Entries shift toward the end only when the back end advances. The last entry falls off.
- hazard = a compared decode source matches one of:
  - i_rr_rd, when i_rr_opcode is LOAD, or
  - any valid scoreboard entry.
- Internal flag pend_redir.
- Priority, evaluated each cycle when not in reset:
  1. **MEMWAIT** (i_mem_busy=1):
     - o_stall_front, o_stall_rr and o_stall_back are 1; both flushes are 0.
     - The scoreboard holds.
     - If i_ex_redirect=1, pend_redir is set.
     - o_memwait_cnt increments.
  2. **FLUSH** (i_ex_redirect or pend_redir):
     - o_flush_front and o_flush_rr are 1; all stalls are 0.
     - pend_redir is cleared.
     - The back end advances, but the squashed RR instruction does not enter the scoreboard.
  3. **HAZARD**:
     - o_stall_front and o_flush_rr are 1; o_stall_rr, o_stall_back and o_flush_front are 0.
     - The back end advances and the scoreboard shifts.
     - o_hazard_cnt increments.
  4. **RUN**: all outputs are 0 and the scoreboard shifts.
- Both counters wrap modulo 2^32.

## Timing
- All strobes are combinational from the current inputs, the scoreboard and pend_redir. Zero-cycle decision latency.
- State (scoreboard, pend_redir, counters) updates on posedge i_clk.
- Load-use penalty for a consumer directly behind a load is LOAD_LAT bubble cycles. At distance d the penalty is max(0, LOAD_LAT+1-d).
- A redirect asserted during MEMWAIT is serviced in the first cycle with i_mem_busy=0. Exactly one flush cycle results, even if i_ex_redirect is also high in that cycle.
- Reset: while i_reset=1, all five strobes are 0, both counters and pend_redir are 0, and all scoreboard entries are invalid. The next cycle after reset deasserts is RUN unless the inputs dictate otherwise.
- Reset asserted during MEMWAIT or HAZARD discards the pending redirect and the scoreboard contents.

## Test plan
- LOAD_LAT=2: RR holds lw x5; decode holds add x6,x5,x1.
  - Expect o_stall_front=o_flush_rr=1 for exactly 2 cycles, then RUN.
  - o_hazard_cnt=2.
- RR holds lw x0; decode holds add x6,x0,x0.
  - Expect no stall in any cycle; o_hazard_cnt stays 0.
- RR holds lw x7; decode holds addi x8,x1,0 whose rs2 field is 7.
  - Expect no stall, because rs2 is not compared for I-type.
- i_mem_busy high for 3 cycles with i_ex_redirect pulsed in the 2nd busy cycle.
  - Expect 3 cycles of all stalls, then 1 cycle of both flushes, then RUN.
  - o_memwait_cnt=3.
- Load-use hazard and i_ex_redirect in the same cycle.
  - Expect o_flush_front=o_flush_rr=1, o_stall_front=0, o_hazard_cnt unchanged.
  - The following cycle shows no hazard, because the load was squashed.
- Assert i_reset for 1 cycle in the middle of a hazard bubble with pend_redir set.
  - Expect all outputs and counters at 0 in the reset cycle.
  - Expect no flush and no stall afterwards with benign inputs.

Source files
------------

// File: rtl/tiny_rv_hazard_ctrl.sv
// Hazard/flush controller for the tiny_rv pipeline: memory wait, redirect squash, load-use bubbles.
// Latency: strobes are combinational (zero-cycle); scoreboard, pending redirect and counters update on i_clk.
// Backpressure: i_mem_busy freezes every stage and banks any redirect until the back end can advance.
module tiny_rv_hazard_ctrl #(
  parameter int LOAD_LAT = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [6:0]  i_dec_opcode,
  input  logic [4:0]  i_dec_rs1,
  input  logic [4:0]  i_dec_rs2,
  input  logic [6:0]  i_rr_opcode,
  input  logic [4:0]  i_rr_rd,
  input  logic        i_mem_busy,
  input  logic        i_ex_redirect,
  output logic        o_stall_front,
  output logic        o_flush_front,
  output logic        o_stall_rr,
  output logic        o_flush_rr,
  output logic        o_stall_back,
  output logic [31:0] o_hazard_cnt,
  output logic [31:0] o_memwait_cnt
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;

  // Loads in flight past RR whose data is not yet forwardable; LOAD_LAT=1 needs none.
  localparam int SB_N = LOAD_LAT - 1;
  localparam int SB_W = (SB_N > 0) ? SB_N : 1;

  logic [SB_W-1:0]      sb_vld_q, sb_vld_d;
  logic [SB_W-1:0][4:0] sb_rd_q, sb_rd_d;
  logic                 pend_redir_q, pend_redir_d;
  logic [31:0]          hazard_cnt_q, hazard_cnt_d;
  logic [31:0]          memwait_cnt_q, memwait_cnt_d;

  logic rr_is_load;
  logic rs1_chk, rs2_chk;
  logic rs1_hit, rs2_hit;
  logic hazard;
  logic mode_memwait, mode_flush, mode_hazard;
  logic advance;

  // Decide which decode sources are real reads and whether either hits an unready load result.
  always_comb begin
    rr_is_load = (i_rr_opcode == OP_LOAD);
    rs1_chk    = (i_dec_rs1 != 5'd0) &&
                 !((i_dec_opcode == OP_LUI) || (i_dec_opcode == OP_AUIPC) || (i_dec_opcode == OP_JAL));
    rs2_chk    = (i_dec_rs2 != 5'd0) &&
                 ((i_dec_opcode == OP_R) || (i_dec_opcode == OP_S) || (i_dec_opcode == OP_B));
    rs1_hit    = rr_is_load && (i_rr_rd == i_dec_rs1);
    rs2_hit    = rr_is_load && (i_rr_rd == i_dec_rs2);
    for (int i = 0; i < SB_W; i++) begin
      if (sb_vld_q[i] && (sb_rd_q[i] == i_dec_rs1)) rs1_hit = 1'b1;
      if (sb_vld_q[i] && (sb_rd_q[i] == i_dec_rs2)) rs2_hit = 1'b1;
    end
    hazard = (rs1_chk && rs1_hit) || (rs2_chk && rs2_hit);
  end

  // Priority select: memory wait beats redirect beats load-use bubble beats run.
  always_comb begin
    mode_memwait  = !i_reset && i_mem_busy;
    mode_flush    = !i_reset && !i_mem_busy && (i_ex_redirect || pend_redir_q);
    mode_hazard   = !i_reset && !i_mem_busy && !(i_ex_redirect || pend_redir_q) && hazard;
    advance       = !i_reset && !i_mem_busy;
    o_stall_front = mode_memwait || mode_hazard;
    o_flush_front = mode_flush;
    o_stall_rr    = mode_memwait;
    o_flush_rr    = mode_flush || mode_hazard;
    o_stall_back  = mode_memwait;
    o_hazard_cnt  = i_reset ? 32'd0 : hazard_cnt_q;
    o_memwait_cnt = i_reset ? 32'd0 : memwait_cnt_q;
  end

  // Next-state: scoreboard shifts only when the back end advances; a squashed RR load never enters.
  always_comb begin
    sb_vld_d      = sb_vld_q;
    sb_rd_d       = sb_rd_q;
    pend_redir_d  = pend_redir_q;
    hazard_cnt_d  = hazard_cnt_q;
    memwait_cnt_d = memwait_cnt_q;
    if (i_reset) begin
      sb_vld_d      = '0;
      sb_rd_d       = '0;
      pend_redir_d  = 1'b0;
      hazard_cnt_d  = 32'd0;
      memwait_cnt_d = 32'd0;
    end else begin
      if (mode_memwait) begin
        pend_redir_d  = pend_redir_q || i_ex_redirect;
        memwait_cnt_d = memwait_cnt_q + 32'd1;
      end
      if (mode_flush) pend_redir_d = 1'b0;
      if (mode_hazard) hazard_cnt_d = hazard_cnt_q + 32'd1;
      if (advance) begin
        for (int i = SB_W - 1; i > 0; i--) begin
          sb_vld_d[i] = sb_vld_q[i-1];
          sb_rd_d[i]  = sb_rd_q[i-1];
        end
        sb_vld_d[0] = !mode_flush && rr_is_load && (i_rr_rd != 5'd0);
        sb_rd_d[0]  = i_rr_rd;
      end
      if (SB_N == 0) sb_vld_d = '0;
    end
  end

  // Register all controller state; reset is folded into the _d logic above.
  always_ff @(posedge i_clk) begin
    sb_vld_q      <= sb_vld_d;
    sb_rd_q       <= sb_rd_d;
    pend_redir_q  <= pend_redir_d;
    hazard_cnt_q  <= hazard_cnt_d;
    memwait_cnt_q <= memwait_cnt_d;
  end

endmodule

// File: tb/tb_tiny_rv_hazard_ctrl.sv
// Bench for tiny_rv_hazard_ctrl: directed scenarios then random traffic against a load-countdown model.
// Inputs change 1 time unit after posedge; outputs are sampled 2 units later.
// Model tracks in-flight loads as (rd, remaining-cycles) records rather than a shift register.
module tb_tiny_rv_hazard_ctrl;

  localparam int LL = 2;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_I     = 7'b0010011;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [6:0]  dec_op, rr_op;
  logic [4:0]  rs1, rs2, rr_rd;
  logic        busy, redir;
  logic        o_stall_front, o_flush_front, o_stall_rr, o_flush_rr, o_stall_back;
  logic [31:0] o_hazard_cnt, o_memwait_cnt;

  tiny_rv_hazard_ctrl #(.LOAD_LAT(LL)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_dec_opcode(dec_op), .i_dec_rs1(rs1), .i_dec_rs2(rs2),
    .i_rr_opcode(rr_op), .i_rr_rd(rr_rd),
    .i_mem_busy(busy), .i_ex_redirect(redir),
    .o_stall_front(o_stall_front), .o_flush_front(o_flush_front),
    .o_stall_rr(o_stall_rr), .o_flush_rr(o_flush_rr), .o_stall_back(o_stall_back),
    .o_hazard_cnt(o_hazard_cnt), .o_memwait_cnt(o_memwait_cnt)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state: loads whose data is still unforwardable, with cycles left.
  typedef struct { logic [4:0] rd; int left; } ld_t;
  ld_t         m_q[$];
  bit          m_pend;
  logic [31:0] m_hz, m_mw;
  int          obs_sf, obs_ff, obs_sb;

  function automatic bit reads_rs1(input logic [6:0] op);
    return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
  endfunction

  function automatic bit reads_rs2(input logic [6:0] op);
    return (op == OP_R || op == OP_S || op == OP_B);
  endfunction

  function automatic bit busy_reg(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    if (rr_op == OP_LOAD && rr_rd == r) return 1'b1;
    foreach (m_q[i]) if (m_q[i].rd == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic set_in(input logic [6:0] dop, input logic [4:0] a, input logic [4:0] b,
                        input logic [6:0] rop, input logic [4:0] rd, input logic bz, input logic rx);
    dec_op = dop; rs1 = a; rs2 = b; rr_op = rop; rr_rd = rd; busy = bz; redir = rx;
  endtask

  // One clock: check outputs against the model, then advance the model across the edge.
  task automatic step(input string tag);
    int mode;
    bit hz;
    ld_t nq[$];
    #2;
    hz = (reads_rs1(dec_op) && busy_reg(rs1)) || (reads_rs2(dec_op) && busy_reg(rs2));
    if (i_reset) mode = 0;
    else if (busy) mode = 1;
    else if (redir || m_pend) mode = 2;
    else if (hz) mode = 3;
    else mode = 4;
    if (o_stall_front === 1'b1) obs_sf++;
    if (o_flush_front === 1'b1) obs_ff++;
    if (o_stall_back === 1'b1) obs_sb++;
    chk({tag, ".stall_front"}, {31'd0, o_stall_front}, {31'd0, mode == 1 || mode == 3});
    chk({tag, ".flush_front"}, {31'd0, o_flush_front}, {31'd0, mode == 2});
    chk({tag, ".stall_rr"}, {31'd0, o_stall_rr}, {31'd0, mode == 1});
    chk({tag, ".flush_rr"}, {31'd0, o_flush_rr}, {31'd0, mode == 2 || mode == 3});
    chk({tag, ".stall_back"}, {31'd0, o_stall_back}, {31'd0, mode == 1});
    chk({tag, ".hz_cnt"}, o_hazard_cnt, i_reset ? 32'd0 : m_hz);
    chk({tag, ".mw_cnt"}, o_memwait_cnt, i_reset ? 32'd0 : m_mw);
    @(posedge i_clk);
    if (mode == 0) begin
      m_q = {}; m_pend = 0; m_hz = 0; m_mw = 0;
    end else if (mode == 1) begin
      m_pend = m_pend || redir;
      m_mw = m_mw + 1;
    end else begin
      if (mode == 2) m_pend = 0;
      if (mode == 3) m_hz = m_hz + 1;
      foreach (m_q[i]) if (m_q[i].left > 1) nq.push_back('{m_q[i].rd, m_q[i].left - 1});
      if (mode != 2 && rr_op == OP_LOAD && rr_rd != 5'd0 && LL > 1) nq.push_back('{rr_rd, LL - 1});
      m_q = nq;
    end
    #1;
  endtask

  logic [6:0] ops[9];
  logic [31:0] base;

  initial begin
    ops = '{OP_LOAD, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_R, OP_S, OP_B, OP_I};
    m_pend = 0; m_hz = 0; m_mw = 0;
    i_reset = 1'b1;
    set_in(OP_I, 0, 0, OP_I, 0, 0, 0);
    @(posedge i_clk); #1;
    step("rst0");
    step("rst1");
    i_reset = 1'b0;

    // Consumer directly behind lw x5: LOAD_LAT bubbles, then run.
    obs_sf = 0;
    set_in(OP_R, 5, 1, OP_LOAD, 5, 0, 0); step("t1a");
    set_in(OP_R, 5, 1, OP_I, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("t1b");
    chk("t1_bubbles", obs_sf, 2);
    chk("t1_hzcnt", o_hazard_cnt, 2);

    // x0 is never a hazard.
    obs_sf = 0;
    set_in(OP_R, 0, 0, OP_LOAD, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("t2");
    chk("t2_nostall", obs_sf, 0);
    chk("t2_hzcnt", o_hazard_cnt, 2);

    // I-type does not read rs2, even if the field matches the load rd.
    obs_sf = 0;
    set_in(OP_I, 1, 7, OP_LOAD, 7, 0, 0);
    for (int i = 0; i < 3; i++) step("t3");
    chk("t3_nostall", obs_sf, 0);

    // Three busy cycles with a redirect in the middle: one deferred flush.
    set_in(OP_I, 0, 0, OP_I, 0, 0, 0); step("t4pre"); step("t4pre");
    base = o_memwait_cnt; obs_sb = 0; obs_ff = 0;
    set_in(OP_I, 0, 0, OP_I, 0, 1, 0); step("t4b1");
    redir = 1'b1; step("t4b2");
    redir = 1'b0; step("t4b3");
    busy = 1'b0; step("t4fl");
    step("t4run");
    chk("t4_mwdelta", o_memwait_cnt - base, 3);
    chk("t4_stalls", obs_sb, 3);
    chk("t4_flushes", obs_ff, 1);

    // Redirect wins over a simultaneous load-use; the load is squashed.
    base = o_hazard_cnt; obs_ff = 0; obs_sf = 0;
    set_in(OP_R, 5, 0, OP_LOAD, 5, 0, 1); step("t5a");
    set_in(OP_R, 5, 0, OP_I, 0, 0, 0); step("t5b");
    chk("t5_flushes", obs_ff, 1);
    chk("t5_nostall", obs_sf, 0);
    chk("t5_hzcnt", o_hazard_cnt, base);

    // Reset mid-bubble with a redirect banked: everything is discarded.
    set_in(OP_R, 5, 0, OP_LOAD, 5, 0, 0); step("t6hz");
    set_in(OP_R, 5, 0, OP_I, 0, 1, 1); step("t6mw");
    i_reset = 1'b1; busy = 1'b0; redir = 1'b0;
    step("t6rst");
    chk("t6_rst_hz", o_hazard_cnt, 0);
    chk("t6_rst_mw", o_memwait_cnt, 0);
    i_reset = 1'b0; obs_sf = 0; obs_ff = 0;
    for (int i = 0; i < 3; i++) step("t6post");
    chk("t6_nostall", obs_sf, 0);
    chk("t6_noflush", obs_ff, 0);

    // Random traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      i_reset = ($urandom_range(0, 99) == 0);
      set_in(ops[$urandom_range(0, 8)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             ops[$urandom_range(0, 8)], 5'($urandom_range(0, 7)),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
      step("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
